// File: rtl/gpr_mt_pkg.sv
// Shared definitions for the multi-thread register file.
// Holds the default bank geometry, the write-enable and reset polarity
// constants, and the clear FSM state encoding.
package gpr_mt_pkg;

    localparam int unsigned GPR_THREAD_NUM = 4;
    localparam int unsigned GPR_REG_NUM    = 32;
    localparam int unsigned GPR_DATA_W     = 32;

    // Both the user write enable and the reset are active-low.
    localparam logic WE_ACTIVE  = 1'b0;
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/gpr_mt_if.sv
// Register file access bus: two read ports sharing one thread id, one write
// port, and the bank-clear request/busy pair.
// master: the requester (drives addresses, write and clear requests).
// slave : the register file (returns read data and clr_busy).
interface gpr_mt_if
    import gpr_mt_pkg::*;
#(
    parameter int unsigned THREAD_NUM = GPR_THREAD_NUM,
    parameter int unsigned REG_NUM    = GPR_REG_NUM,
    parameter int unsigned DATA_W     = GPR_DATA_W
);
    localparam int unsigned TID_W  = $clog2(THREAD_NUM);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);

    logic [TID_W-1:0]  rd_tid;
    logic [ADDR_W-1:0] rd_addr_0;
    logic [DATA_W-1:0] rd_data_0;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [DATA_W-1:0] rd_data_1;
    logic              we_;
    logic [TID_W-1:0]  wr_tid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic [TID_W-1:0]  clr_tid;
    logic              clr_busy;

    modport master (
        output rd_tid, rd_addr_0, rd_addr_1,
        output we_, wr_tid, wr_addr, wr_data,
        output clr_req, clr_tid,
        input  rd_data_0, rd_data_1, clr_busy
    );

    modport slave (
        input  rd_tid, rd_addr_0, rd_addr_1,
        input  we_, wr_tid, wr_addr, wr_data,
        input  clr_req, clr_tid,
        output rd_data_0, rd_data_1, clr_busy
    );

endinterface

// File: rtl/gpr_clr_fsm.sv
// Bank-clear sequencer: on a request in IDLE, latches the bank id and walks
// a counter over every register of that bank, one zero-write per cycle.
// Ports: clk, reset (sync, active-low), clr_req/clr_tid (request),
//        clr_we/clr_wtid/clr_waddr (clear write port), clr_busy.
module gpr_clr_fsm
    import gpr_mt_pkg::*;
#(
    parameter int unsigned TID_W   = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned REG_NUM = GPR_REG_NUM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic [TID_W-1:0]  clr_tid,
    output logic              clr_we,
    output logic [TID_W-1:0]  clr_wtid,
    output logic [ADDR_W-1:0] clr_waddr,
    output logic              clr_busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);

    clr_state_e        state_q, state_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // State, latched bank, counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            state_q <= IDLE;
            tid_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; requests arriving while CLEAR runs are dropped.
    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    tid_d   = clr_tid;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    assign clr_we    = (state_q == CLEAR);
    assign clr_wtid  = tid_q;
    assign clr_waddr = cnt_q;
    assign clr_busy  = busy_q;

endmodule

// File: rtl/gpr_mt.sv
// Multi-thread general purpose register file: THREAD_NUM banks of REG_NUM
// registers, two zero-latency read ports, one active-low write port and a
// per-bank background clear.
// Ports: clk, reset (sync, active-low), bus (gpr_mt_if.slave: reads,
//        write, clr_req/clr_tid, clr_busy).
// Build option: GPR_BYPASS_EN forwards a same-cycle write to matching reads.
module gpr_mt
    import gpr_mt_pkg::*;
#(
    parameter int unsigned THREAD_NUM = GPR_THREAD_NUM,
    parameter int unsigned REG_NUM    = GPR_REG_NUM,
    parameter int unsigned DATA_W     = GPR_DATA_W
) (
    input  logic     clk,
    input  logic     reset,
    gpr_mt_if.slave  bus
);
    localparam int unsigned TID_W  = $clog2(THREAD_NUM);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);

    logic [DATA_W-1:0] mem_q [THREAD_NUM][REG_NUM];
    logic [DATA_W-1:0] mem_d [THREAD_NUM][REG_NUM];

    logic              clr_we;
    logic [TID_W-1:0]  clr_wtid;
    logic [ADDR_W-1:0] clr_waddr;
    logic              clr_busy;

    gpr_clr_fsm #(
        .TID_W   (TID_W),
        .ADDR_W  (ADDR_W),
        .REG_NUM (REG_NUM)
    ) u_clr_fsm (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (bus.clr_req),
        .clr_tid   (bus.clr_tid),
        .clr_we    (clr_we),
        .clr_wtid  (clr_wtid),
        .clr_waddr (clr_waddr),
        .clr_busy  (clr_busy)
    );

    assign bus.clr_busy = clr_busy;

    // Array update; the user write is applied last so it wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_wtid][clr_waddr] = '0;
        end
        if (bus.we_ == WE_ACTIVE) begin
            mem_d[bus.wr_tid][bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports see stored state; clear writes are never forwarded.
    always_comb begin
        bus.rd_data_0 = mem_q[bus.rd_tid][bus.rd_addr_0];
        bus.rd_data_1 = mem_q[bus.rd_tid][bus.rd_addr_1];
`ifdef GPR_BYPASS_EN
        if (bus.we_ == WE_ACTIVE && bus.wr_tid == bus.rd_tid) begin
            if (bus.wr_addr == bus.rd_addr_0) bus.rd_data_0 = bus.wr_data;
            if (bus.wr_addr == bus.rd_addr_1) bus.rd_data_1 = bus.wr_data;
        end
`else
`endif
    end

endmodule

// File: tb/tb_gpr_mt.sv
// Self-checking bench for gpr_mt: random traffic plus directed scenarios,
// checked against an array-based model of the register file.
module tb_gpr_mt;
    import gpr_mt_pkg::*;

    localparam int unsigned TN = 4;
    localparam int unsigned RN = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 2;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpr_mt_if #(.THREAD_NUM(TN), .REG_NUM(RN), .DATA_W(DW)) bus();

    gpr_mt #(.THREAD_NUM(TN), .REG_NUM(RN), .DATA_W(DW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: stored register contents plus remaining clear cycles.
    logic [DW-1:0] m [TN][RN];
    int clr_left = 0;
    int clr_t    = 0;
    int busy_cnt;

    function automatic logic [DW-1:0] exp_rd(input int t, input int a);
        logic [DW-1:0] v;
        v = m[t][a];
`ifdef GPR_BYPASS_EN
        if (bus.we_ == 1'b0 && int'(bus.wr_tid) == t && int'(bus.wr_addr) == a)
            v = bus.wr_data;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_now(input string tag);
        logic [DW-1:0] eb;
        #1;
        eb = (clr_left > 0) ? DW'(1) : DW'(0);
        chk({tag, "_rd0"}, bus.rd_data_0, exp_rd(int'(bus.rd_tid), int'(bus.rd_addr_0)));
        chk({tag, "_rd1"}, bus.rd_data_1, exp_rd(int'(bus.rd_tid), int'(bus.rd_addr_1)));
        chk({tag, "_busy"}, DW'(bus.clr_busy), eb);
    endtask

    // Advance the model by one clock using the current inputs, then the DUT.
    task automatic tick();
        if (reset == 1'b0) begin
            foreach (m[t, a]) m[t][a] = '0;
            clr_left = 0;
        end else begin
            if (clr_left > 0) begin
                m[clr_t][RN - clr_left] = '0;
                clr_left--;
            end else if (bus.clr_req) begin
                clr_t    = int'(bus.clr_tid);
                clr_left = RN;
            end
            if (bus.we_ == 1'b0) m[bus.wr_tid][bus.wr_addr] = bus.wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    // Read every entry of every bank while idle.
    task automatic sweep(input string tag);
        bus.we_     = 1'b1;
        bus.clr_req = 1'b0;
        for (int t = 0; t < TN; t++) begin
            for (int a = 0; a < RN; a += 2) begin
                bus.rd_tid    = TW'(t);
                bus.rd_addr_0 = AW'(a);
                bus.rd_addr_1 = AW'(a + 1);
                #1;
                chk({tag, "_p0"}, bus.rd_data_0, exp_rd(t, a));
                chk({tag, "_p1"}, bus.rd_data_1, exp_rd(t, a + 1));
            end
        end
    endtask

    task automatic rand_reads();
        bus.rd_tid    = TW'($urandom);
        bus.rd_addr_0 = AW'($urandom);
        bus.rd_addr_1 = AW'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        bus.we_ = 1'b1; bus.wr_tid = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_req = 1'b0; bus.clr_tid = '0;
        bus.rd_tid = '0; bus.rd_addr_0 = '0; bus.rd_addr_1 = '0;
        tick();
        tick();
        reset = 1'b1;
        chk_now("reset");
        sweep("post_reset");

        // Random traffic, occasional clears and read/write address aliasing.
        repeat (300) begin
            bus.we_     = 1'($urandom);
            bus.wr_tid  = TW'($urandom);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
            rand_reads();
            if ($urandom_range(0, 3) == 0) begin
                bus.rd_tid    = bus.wr_tid;
                bus.rd_addr_0 = bus.wr_addr;
            end
            bus.clr_req = ($urandom_range(0, 31) == 0);
            bus.clr_tid = TW'($urandom);
            chk_now("rand");
            tick();
        end
        bus.clr_req = 1'b0;
        bus.we_     = 1'b1;
        for (int i = 0; i < int'(RN) + 2; i++) if (clr_left > 0) tick();
        chk_now("drain");

        // Reset after arbitrary writes, with a write in the reset cycle.
        reset = 1'b0;
        bus.we_ = 1'b0; bus.wr_tid = 2'd1; bus.wr_addr = 5'd3; bus.wr_data = 32'hABCD0123;
        tick();
        reset = 1'b1;
        bus.we_ = 1'b1;
        chk_now("rst_after_wr");
        sweep("rst_all_zero");

        // Same-cycle write/read of tid2/r5.
        bus.we_ = 1'b0; bus.wr_tid = 2'd2; bus.wr_addr = 5'd5; bus.wr_data = 32'h11111111;
        tick();
        bus.wr_data = 32'hDEADBEEF;
        bus.rd_tid = 2'd2; bus.rd_addr_0 = 5'd5; bus.rd_addr_1 = 5'd5;
        chk_now("wr_same_cycle");
`ifdef GPR_BYPASS_EN
        chk("wr_same_cycle_const", bus.rd_data_0, 32'hDEADBEEF);
`else
        chk("wr_same_cycle_const", bus.rd_data_0, 32'h11111111);
`endif
        tick();
        bus.we_ = 1'b1;
        #1;
        chk("wr_next_cycle", bus.rd_data_0, 32'hDEADBEEF);
        chk("wr_next_cycle_p1", bus.rd_data_1, 32'hDEADBEEF);

        // Bank isolation.
        bus.we_ = 1'b0; bus.wr_tid = 2'd1; bus.wr_addr = 5'd7; bus.wr_data = 32'h00001234;
        tick();
        bus.we_ = 1'b1;
        bus.rd_tid = 2'd0; bus.rd_addr_0 = 5'd7; bus.rd_addr_1 = 5'd7;
        #1;
        chk("bank_iso_t0", bus.rd_data_0, 32'h0);
        bus.rd_tid = 2'd1;
        #1;
        chk("bank_iso_t1", bus.rd_data_1, 32'h00001234);

        // Fill every bank, then clear tid3 with a user write colliding at r10.
        for (int t = 0; t < TN; t++) begin
            for (int a = 0; a < RN; a++) begin
                bus.we_ = 1'b0; bus.wr_tid = TW'(t); bus.wr_addr = AW'(a);
                bus.wr_data = DW'($urandom) | 32'h1;
                tick();
            end
        end
        bus.we_ = 1'b1;
        bus.clr_req = 1'b1; bus.clr_tid = 2'd3;
        chk_now("clr_start");
        tick();
        bus.clr_req = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < int'(RN) + 8; i++) begin
            rand_reads();
            if (clr_left > 0 && (int'(RN) - clr_left) == 10) begin
                bus.we_ = 1'b0; bus.wr_tid = 2'd3; bus.wr_addr = 5'd10; bus.wr_data = 32'h55;
                bus.rd_tid = 2'd3; bus.rd_addr_0 = 5'd10;
            end else begin
                bus.we_ = 1'b1;
            end
            bus.clr_req = (clr_left > 1);
            bus.clr_tid = 2'd0;
            chk_now("clr_run");
            if (bus.clr_busy) busy_cnt++;
            tick();
        end
        bus.clr_req = 1'b0;
        bus.we_     = 1'b1;
        chk("clr_busy_cycles", DW'(busy_cnt), DW'(RN));
        sweep("after_clear");
        bus.rd_tid = 2'd3; bus.rd_addr_0 = 5'd10; bus.rd_addr_1 = 5'd0;
        #1;
        chk("clr_user_wins", bus.rd_data_0, 32'h55);
        chk("clr_t3_r0", bus.rd_data_1, 32'h0);

        // Reset in the middle of a clear of tid0.
        bus.clr_req = 1'b1; bus.clr_tid = 2'd0;
        tick();
        bus.clr_req = 1'b0;
        repeat (16) tick();
        chk_now("mid_clear");
        reset = 1'b0;
        bus.we_ = 1'b0; bus.wr_tid = 2'd1; bus.wr_addr = 5'd9; bus.wr_data = 32'hCAFEF00D;
        tick();
        reset = 1'b1;
        bus.we_ = 1'b1;
        chk_now("abort_busy");
        chk("abort_busy_const", DW'(bus.clr_busy), 32'h0);
        sweep("abort_zero");

        // No residual clear writes after the aborted clear.
        bus.we_ = 1'b0; bus.wr_tid = 2'd0; bus.wr_addr = 5'd20; bus.wr_data = 32'h77;
        tick();
        bus.we_ = 1'b1;
        repeat (RN) tick();
        bus.rd_tid = 2'd0; bus.rd_addr_0 = 5'd20; bus.rd_addr_1 = 5'd31;
        chk_now("no_residual");
        chk("no_residual_const", bus.rd_data_0, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
